// File: rtl/imem_dmem_bus_arbiter.sv
// Arbitrates fetch and data requesters onto one downstream req/ready bus; ARB_ROUND_ROBIN_EN selects round-robin ties (default: data wins).
// Latency: grant -> m_req next cycle, port ready one cycle after m_ready; no new grant until the current transfer completes.
module imem_dmem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_req,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  output logic              i_error,

  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  input  logic              d_wr,
  input  logic              d_req,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_error,

  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wr,
  output logic              m_req,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready,
  input  logic              m_error,

  output logic              grant_d,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [3:0]        m_wstrb_q;
  logic              m_wr_q;
  logic              grant_d_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic any_req;
  logic pick_d;
  logic sample;
  logic timeout_hit;

  assign any_req = i_req | d_req;
  assign sample  = (state_q == S_IDLE) && any_req;

  // grant_d_q doubles as the last-grant register: it resets to fetch and reloads on every grant.
`ifdef ARB_ROUND_ROBIN_EN
  assign pick_d = d_req && (!i_req || !grant_d_q);
`else
  assign pick_d = d_req;
`endif

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (m_ready || timeout_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      m_wr_q    <= 1'b0;
      grant_d_q <= 1'b0;
    end else if (sample) begin
      grant_d_q <= pick_d;
      m_addr_q  <= pick_d ? d_addr : i_addr;
      m_wdata_q <= pick_d ? d_wdata : 32'h0;
      m_wstrb_q <= pick_d ? d_wstrb : 4'hF;
      m_wr_q    <= pick_d & d_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == S_DONE) begin
      cnt_q <= '0;
    end
  end

  // A real response beats a coinciding timeout; only the granted port's data register moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (m_ready) begin
        err_q <= m_error;
        if (grant_d_q) d_rdata_q <= m_rdata;
        else           i_rdata_q <= m_rdata;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
        if (grant_d_q) d_rdata_q <= '0;
        else           i_rdata_q <= '0;
      end
    end
  end

  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign m_wr    = m_wr_q;
  assign m_req   = (state_q == S_ISSUE);
  assign grant_d = grant_d_q;
  assign busy    = (state_q != S_IDLE);

  assign i_ready = (state_q == S_DONE) && !grant_d_q;
  assign d_ready = (state_q == S_DONE) &&  grant_d_q;
  assign i_error = i_ready & err_q;
  assign d_error = d_ready & err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_imem_dmem_bus_arbiter.sv
// Randomized self-checking bench for imem_dmem_bus_arbiter with a reactive slave and a request-level reference model.
module tb_imem_dmem_bus_arbiter;
  localparam int AW = 32;
  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0, m_addr;
  logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [31:0]   d_wdata = '0, i_rdata, d_rdata, m_wdata, m_rdata;
  logic [3:0]    d_wstrb = '0, m_wstrb;
  logic          i_ready, i_error, d_ready, d_error, m_wr, m_req, grant_d, busy;
  logic          m_ready, m_error;

  imem_dmem_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_req(i_req), .i_rdata(i_rdata), .i_ready(i_ready), .i_error(i_error),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wr(d_wr), .d_req(d_req),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_error(d_error),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wr(m_wr), .m_req(m_req),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
    .grant_d(grant_d), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave: answers each m_req after s_delay_cur wait cycles unless hung; can inject one stray m_ready.
  bit          s_hang = 1'b0;
  bit          s_fixed = 1'b0;
  int          s_fix_delay = 0;
  logic [31:0] s_fix_data = '0;
  int          s_inject_at = -1;
  bit          s_pending = 1'b0;
  int          s_cnt = 0;
  int          s_delay_cur = 0;
  logic [31:0] s_rdata_cur = '0;
  logic        s_err_cur = 1'b0;

  initial begin
    m_ready = 1'b0; m_rdata = '0; m_error = 1'b0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      m_error = 1'b0;
      if (!rst_n) begin
        s_pending = 1'b0;
      end else begin
        if (s_pending) begin
          if (s_cnt == 0) begin
            m_ready = 1'b1; m_rdata = s_rdata_cur; m_error = s_err_cur; s_pending = 1'b0;
          end else s_cnt--;
        end
        if (cyc == s_inject_at) begin
          m_ready = 1'b1; m_rdata = 32'hBAD0_BAD0; m_error = 1'b1;
        end
        if (m_req && !s_hang) begin
          s_pending = 1'b1;
          if (s_fixed) begin
            s_delay_cur = s_fix_delay; s_rdata_cur = s_fix_data; s_err_cur = 1'b0;
          end else begin
            s_delay_cur = $urandom_range(0, 4);
            s_rdata_cur = $urandom;
            s_err_cur   = ($urandom_range(0, 5) == 0);
          end
          s_cnt = s_delay_cur;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({m_addr, m_wdata, m_wstrb, m_wr, m_req} !== '0) begin
      n_bad++; $display("FAIL reset_m_bus: got %h required 0", {m_addr, m_wdata, m_wstrb, m_wr, m_req});
    end
    n_cmp++;
    if ({i_rdata, i_ready, i_error, d_rdata, d_ready, d_error} !== '0) begin
      n_bad++; $display("FAIL reset_port_resp: got %h required 0", {i_rdata, i_ready, i_error, d_rdata, d_ready, d_error});
    end
    n_cmp++;
    if ({grant_d, busy} !== 2'b00) begin
      n_bad++; $display("FAIL reset_status: got grant_d=%b busy=%b required 0 0", grant_d, busy);
    end
    rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if (busy !== 1'b0 || m_req !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_req: got busy=%b m_req=%b required 0 0", busy, m_req);
    end
  endtask

  task automatic test_single_fetch();
    int t_req, nreq, got;
    t_req = 0; nreq = 0; got = 0;
    s_fixed = 1'b1; s_fix_delay = 0; s_fix_data = 32'h0000_0013;
    i_addr = 32'h0000_0100; i_req = 1'b1;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step();
      if (m_req) begin
        nreq++; t_req = cyc;
        n_cmp++;
        if ({m_addr, m_wr, m_wstrb, grant_d} !== {32'h0000_0100, 1'b0, 4'hF, 1'b0}) begin
          n_bad++; $display("FAIL fetch_m_bus: got addr=%h wr=%b wstrb=%h gd=%b required 100 0 f 0", m_addr, m_wr, m_wstrb, grant_d);
        end
      end
      n_cmp++;
      if (d_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_d_ready: got %b required 0", d_ready); end
      if (i_ready) begin
        got = 1; i_req = 1'b0;
        n_cmp++;
        if ({i_rdata, i_error} !== {32'h0000_0013, 1'b0}) begin
          n_bad++; $display("FAIL fetch_resp: got rdata=%h err=%b required 00000013 0", i_rdata, i_error);
        end
        n_cmp++;
        if (cyc - t_req !== 2) begin n_bad++; $display("FAIL fetch_latency: got %0d required 2", cyc - t_req); end
      end
    end
    n_cmp++;
    if (got !== 1) begin n_bad++; $display("FAIL fetch_done: got %0d required 1", got); end
    step();
    n_cmp++;
    if ({i_ready, i_rdata} !== {1'b0, 32'h0000_0013}) begin
      n_bad++; $display("FAIL fetch_hold: got ready=%b rdata=%h required 0 00000013", i_ready, i_rdata);
    end
  endtask

  task automatic test_data_write();
    int t_req, got, nd, ni;
    t_req = 0; got = 0; nd = 0; ni = 0;
    s_fixed = 1'b1; s_fix_delay = 1; s_fix_data = 32'h1234_5678;
    d_addr = 32'h2000_0004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; d_wr = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m_req) begin
        t_req = cyc;
        n_cmp++;
        if ({m_addr, m_wdata, m_wstrb, m_wr, grant_d} !== {32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b1}) begin
          n_bad++; $display("FAIL write_m_bus: got %h %h %b %b gd=%b required 20000004 deadbeef 0011 1 1", m_addr, m_wdata, m_wstrb, m_wr, grant_d);
        end
      end
      if (i_ready) ni++;
      if (d_ready) begin
        nd++; d_req = 1'b0;
        n_cmp++;
        if ({d_error, d_rdata} !== {1'b0, 32'h1234_5678} || cyc - t_req !== 3) begin
          n_bad++; $display("FAIL write_resp: got err=%b rdata=%h lat=%0d required 0 12345678 3", d_error, d_rdata, cyc - t_req);
        end
      end
    end
    d_wr = 1'b0;
    n_cmp++;
    if (nd !== 1 || ni !== 0) begin n_bad++; $display("FAIL write_pulses: got d=%0d i=%0d required 1 0", nd, ni); end
  endtask

  task automatic test_hold_off();
    int nreq, got;
    nreq = 0; got = 0;
    s_fixed = 1'b1; s_fix_delay = 2; s_fix_data = 32'hCAFE_0001;
    i_addr = 32'h0000_0200; i_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (got == 1) begin i_req = 1'b0; got = 2; end
      if (m_req) nreq++;
      if (i_ready) got = 1;
    end
    n_cmp++;
    if (nreq !== 1 || got !== 2) begin n_bad++; $display("FAIL hold_off: got m_req=%0d done=%0d required 1 2", nreq, got); end
  endtask

  task automatic test_arbitration();
    bit exp_q[$];
    bit last, g;
    int ni, nd, idx;
    do_reset();
    ni = 2; nd = 2; last = 1'b0;
    while (ni != 0 || nd != 0) begin
      if (ni != 0 && nd != 0) g = RR ? !last : 1'b1;
      else g = (nd != 0);
      exp_q.push_back(g); last = g;
      if (g) nd--; else ni--;
    end
    s_fixed = 1'b0;
    ni = 2; nd = 2; idx = 0;
    i_addr = $urandom; d_addr = $urandom; d_wr = 1'b0; i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 200 && idx < 4; k++) begin
      step();
      if (m_req) begin
        n_cmp++;
        if (grant_d !== exp_q[idx] || m_addr !== (exp_q[idx] ? d_addr : i_addr)) begin
          n_bad++; $display("FAIL arb_grant%0d: got gd=%b addr=%h required gd=%b", idx, grant_d, m_addr, exp_q[idx]);
        end
      end
      if (i_ready || d_ready) begin
        n_cmp++;
        if (d_ready !== exp_q[idx] || i_ready === d_ready) begin
          n_bad++; $display("FAIL arb_ready%0d: got i=%b d=%b required d=%b", idx, i_ready, d_ready, exp_q[idx]);
        end
        if (d_ready) begin nd--; if (nd == 0) d_req = 1'b0; else d_addr = $urandom; end
        if (i_ready) begin ni--; if (ni == 0) i_req = 1'b0; else i_addr = $urandom; end
        idx++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    n_cmp++;
    if (idx !== 4) begin n_bad++; $display("FAIL arb_count: got %0d required 4", idx); end
    step(); step();
  endtask

  task automatic test_random();
    bit pi, pd, exp_g, in_txn, mdl_last;
    int t_req, n_done;
    do_reset();
    s_fixed = 1'b0; mdl_last = 1'b0; in_txn = 1'b0; exp_g = 1'b0; t_req = 0; n_done = 0;
    for (int k = 0; k < 1500; k++) begin
      pi = i_req; pd = d_req;
      step();
      if (m_req) begin
        exp_g = (pi && pd) ? (RR ? !mdl_last : 1'b1) : pd;
        mdl_last = exp_g; t_req = cyc; in_txn = 1'b1;
        n_cmp++;
        if (grant_d !== exp_g || m_addr !== (exp_g ? d_addr : i_addr) || m_wr !== (exp_g & d_wr)
            || m_wstrb !== (exp_g ? d_wstrb : 4'hF) || (exp_g && m_wdata !== d_wdata)) begin
          n_bad++; $display("FAIL rnd_issue: got gd=%b addr=%h wr=%b wstrb=%h required gd=%b", grant_d, m_addr, m_wr, m_wstrb, exp_g);
        end
      end
      if (i_ready || d_ready) begin
        n_cmp++;
        if (!in_txn || {d_ready, i_ready} !== (exp_g ? 2'b10 : 2'b01) || cyc - t_req !== s_delay_cur + 2) begin
          n_bad++; $display("FAIL rnd_ready: got i=%b d=%b lat=%0d required gd=%b lat=%0d", i_ready, d_ready, cyc - t_req, exp_g, s_delay_cur + 2);
        end
        n_cmp++;
        if ((exp_g ? {d_rdata, d_error} : {i_rdata, i_error}) !== {s_rdata_cur, s_err_cur}) begin
          n_bad++; $display("FAIL rnd_data: got i=%h/%b d=%h/%b required %h/%b", i_rdata, i_error, d_rdata, d_error, s_rdata_cur, s_err_cur);
        end
        if (d_ready) d_req = 1'b0;
        if (i_ready) i_req = 1'b0;
        in_txn = 1'b0; n_done++;
      end else begin
        if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom); d_wr = 1'($urandom);
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    n_cmp++;
    if (n_done < 50) begin n_bad++; $display("FAIL rnd_progress: got %0d required >=50", n_done); end
    for (int k = 0; k < 12; k++) step();
  endtask

  task automatic test_timeout();
    int t_req, got;
    t_req = 0; got = 0;
    s_hang = 1'b1;
    i_addr = 32'h0000_0300; i_req = 1'b1;
    for (int k = 0; k < 30 && got == 0; k++) begin
      step();
      if (m_req) t_req = cyc;
      if (i_ready) begin
        got = 1; i_req = 1'b0; s_inject_at = cyc + 3;
        n_cmp++;
        if ({i_rdata, i_error, cyc - t_req} !== {32'h0, 1'b1, 32'd9}) begin
          n_bad++; $display("FAIL timeout_resp: got rdata=%h err=%b lat=%0d required 0 1 9", i_rdata, i_error, cyc - t_req);
        end
      end
    end
    n_cmp++;
    if (got !== 1) begin n_bad++; $display("FAIL timeout_done: got %0d required 1", got); end
    s_hang = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if ({busy, m_req, i_ready, d_ready} !== 4'b0 || i_rdata !== 32'h0) begin
        n_bad++; $display("FAIL late_ready: got busy=%b m_req=%b i=%b d=%b rdata=%h required 0", busy, m_req, i_ready, d_ready, i_rdata);
      end
    end
    s_inject_at = -1;
  endtask

  task automatic test_reset_mid_wait();
    int got, seen;
    got = 0; seen = 0;
    s_hang = 1'b1;
    d_addr = 32'h4000_0000; d_wr = 1'b1; d_wdata = 32'h5555_AAAA; d_wstrb = 4'hF; d_req = 1'b1;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      step();
      if (m_req) seen = 1;
    end
    step(); step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_addr, m_wdata, m_wstrb, m_wr, m_req, i_ready, d_ready, d_rdata, grant_d, busy} !== '0) begin
      n_bad++; $display("FAIL rst_wait: got busy=%b gd=%b m_addr=%h d_ready=%b required all 0", busy, grant_d, m_addr, d_ready);
    end
    d_req = 1'b0; d_wr = 1'b0; s_hang = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({i_ready, d_ready, busy} !== 3'b0) begin
        n_bad++; $display("FAIL rst_hold: got i=%b d=%b busy=%b required 0", i_ready, d_ready, busy);
      end
    end
    rst_n = 1'b1;
    step();
    s_fixed = 1'b1; s_fix_delay = 0; s_fix_data = 32'h7777_0001;
    i_addr = 32'h0000_0400; i_req = 1'b1;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step();
      if (d_ready) begin n_bad++; n_cmp++; $display("FAIL post_rst_d: got d_ready=1 required 0"); end
      if (i_ready) begin
        got = 1; i_req = 1'b0;
        n_cmp++;
        if ({i_rdata, i_error} !== {32'h7777_0001, 1'b0}) begin
          n_bad++; $display("FAIL post_rst_resp: got %h/%b required 77770001/0", i_rdata, i_error);
        end
      end
    end
    n_cmp++;
    if (got !== 1) begin n_bad++; $display("FAIL post_rst_done: got %0d required 1", got); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_hold_off();
    test_arbitration();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
